ili934x_spi_tx: RTL and testbench



---
 rtl/ili934x_spi_tx_if.sv | 22 ++
 rtl/ili934x_spi_tx.sv | 116 +++++++++++
 tb/tb_ili934x_spi_tx.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ili934x_spi_tx_if.sv
// Write-item handshake plus the ILI934x 4-wire SPI write bus.
// The transmitter is the slave side; whoever feeds items and watches the bus is the master side.
interface ili934x_spi_tx_if;
  logic       i_valid;
  logic [8:0] i_item;    // {is_cmd, byte[7:0]}
  logic       i_ready;
  logic       lcd_cs_n;
  logic       lcd_dc;
  logic       lcd_sck;
  logic       lcd_mosi;
  logic       busy;

  modport master (
    output i_valid, i_item,
    input  i_ready, lcd_cs_n, lcd_dc, lcd_sck, lcd_mosi, busy
  );

  modport slave (
    input  i_valid, i_item,
    output i_ready, lcd_cs_n, lcd_dc, lcd_sck, lcd_mosi, busy
  );
endinterface

// File: rtl/ili934x_spi_tx.sv
// ILI934x SPI write transmitter: pops {is_cmd, byte} items and shifts them out MSB first
// in SPI mode 0, keeping CS# low for up to CS_HOLD idle cycles so bursts share one select.
module ili934x_spi_tx #(
  parameter int CLK_DIV = 2,
  parameter int CS_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  ili934x_spi_tx_if.slave bus
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int HW = (CS_HOLD > 0) ? $clog2(CS_HOLD + 1) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((CS_HOLD > 0) ? CS_HOLD - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t        state_reg;
  logic [DW-1:0] div_reg;
  logic [HW-1:0] hold_reg;
  logic [2:0]    bit_reg;
  logic [7:0]    shift_reg;
  logic          cs_n_reg;
  logic          dc_reg;
  logic          sck_reg;
  logic          mosi_reg;
  logic          ready_reg;
  logic          busy_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      div_reg   <= '0;
      hold_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      cs_n_reg  <= 1'b1;
      dc_reg    <= 1'b0;
      sck_reg   <= 1'b0;
      mosi_reg  <= 1'b0;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
    end else if (bus.i_valid && ready_reg) begin
      // ready is only high in IDLE/GAP, where SCK is low, so DC/MOSI may change here.
      // Taking priority over the GAP timeout keeps CS# low when both coincide.
      shift_reg <= bus.i_item[7:0];
      dc_reg    <= ~bus.i_item[8];
      mosi_reg  <= bus.i_item[7];
      cs_n_reg  <= 1'b0;
      bit_reg   <= 3'd7;
      div_reg   <= '0;
      hold_reg  <= '0;
      state_reg <= SETUP;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b1;
    end else begin
      case (state_reg)
        SETUP: begin
          if (div_reg == DIV_LAST) begin
            div_reg   <= '0;
            state_reg <= SHIFT;
          end else begin
            div_reg <= div_reg + DW'(1);
          end
        end
        SHIFT: begin
          if (div_reg == DIV_LAST) begin
            div_reg <= '0;
            sck_reg <= ~sck_reg;
            if (sck_reg) begin
              // falling edge: advance to the next bit or finish the byte
              if (bit_reg == 3'd0) begin
                ready_reg <= 1'b1;
                if (CS_HOLD > 0) begin
                  hold_reg  <= '0;
                  state_reg <= GAP;
                end else begin
                  cs_n_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
                end
              end else begin
                bit_reg   <= bit_reg - 3'd1;
                shift_reg <= {shift_reg[6:0], 1'b0};
                mosi_reg  <= shift_reg[6];
              end
            end
          end else begin
            div_reg <= div_reg + DW'(1);
          end
        end
        GAP: begin
          if (hold_reg == HOLD_LAST) begin
            hold_reg  <= '0;
            cs_n_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            hold_reg <= hold_reg + HW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.i_ready  = ready_reg;
  assign bus.lcd_cs_n = cs_n_reg;
  assign bus.lcd_dc   = dc_reg;
  assign bus.lcd_sck  = sck_reg;
  assign bus.lcd_mosi = mosi_reg;
  assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_ili934x_spi_tx.sv
// Bench for ili934x_spi_tx: three instances (CLK_DIV/CS_HOLD = 2/4, 2/0, 1/4) whose SPI buses
// are decoded back into items and compared with what the handshake accepted.
module tb_ili934x_spi_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ili934x_spi_tx_if bus_a ();
  ili934x_spi_tx_if bus_b ();
  ili934x_spi_tx_if bus_c ();

  logic [2:0] vld = '0;
  logic [8:0] itm [3];

  assign bus_a.i_valid = vld[0];
  assign bus_b.i_valid = vld[1];
  assign bus_c.i_valid = vld[2];
  assign bus_a.i_item  = itm[0];
  assign bus_b.i_item  = itm[1];
  assign bus_c.i_item  = itm[2];

  wire [2:0] rdy  = {bus_c.i_ready,  bus_b.i_ready,  bus_a.i_ready};
  wire [2:0] csn  = {bus_c.lcd_cs_n, bus_b.lcd_cs_n, bus_a.lcd_cs_n};
  wire [2:0] dcs  = {bus_c.lcd_dc,   bus_b.lcd_dc,   bus_a.lcd_dc};
  wire [2:0] sck  = {bus_c.lcd_sck,  bus_b.lcd_sck,  bus_a.lcd_sck};
  wire [2:0] mosi = {bus_c.lcd_mosi, bus_b.lcd_mosi, bus_a.lcd_mosi};
  wire [2:0] bsy  = {bus_c.busy,     bus_b.busy,     bus_a.busy};

  ili934x_spi_tx #(.CLK_DIV(2), .CS_HOLD(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  ili934x_spi_tx #(.CLK_DIV(2), .CS_HOLD(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  ili934x_spi_tx #(.CLK_DIV(1), .CS_HOLD(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  // Bus decoder state, one slot per instance
  int         nb [3];
  int         rises [3];
  int         viol [3];
  int         cs_rises [3];
  int         last_fall [3];
  int         cnt [3];
  int         ready_at [3];
  int         rdy_bad [3];
  logic [7:0] sh [3];
  logic       fdc [3];
  logic       p_sck [3];
  logic       p_mosi [3];
  logic       p_dc [3];
  logic       p_cs [3];
  logic [8:0] cap [3][128];
  logic [8:0] expq [64];

  initial begin
    for (int i = 0; i < 3; i++) begin
      nb[i] = 0; rises[i] = 0; viol[i] = 0; cs_rises[i] = 0; last_fall[i] = 0;
      cnt[i] = 0; ready_at[i] = 0; rdy_bad[i] = 0; sh[i] = '0; fdc[i] = 1'b0;
      p_sck[i] = 1'b0; p_mosi[i] = 1'b0; p_dc[i] = 1'b0; p_cs[i] = 1'b1;
      itm[i] = '0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        nb[i] = 0;
      end else begin
        if (bsy[i] !== ~csn[i]) viol[i]++;
        if (sck[i] && !p_sck[i]) begin
          rises[i]++;
          if (csn[i]) viol[i]++;
          if (nb[i] == 0) fdc[i] = dcs[i];
          else if (dcs[i] !== fdc[i]) viol[i]++;
          sh[i] = {sh[i][6:0], mosi[i]};
          nb[i]++;
          if (nb[i] == 8) begin
            if (cnt[i] < 128) cap[i][cnt[i]] = {~fdc[i], sh[i]};
            cnt[i]++;
            nb[i] = 0;
          end
        end
        if (!sck[i] && p_sck[i]) last_fall[i] = cyc;
        if (sck[i] && p_sck[i] && (mosi[i] !== p_mosi[i] || dcs[i] !== p_dc[i])) viol[i]++;
        if (csn[i] && !p_cs[i]) cs_rises[i]++;
      end
      p_sck[i]  = sck[i];
      p_mosi[i] = mosi[i];
      p_dc[i]   = dcs[i];
      p_cs[i]   = csn[i];
    end
  end

  function automatic int div_of(input int b);
    return (b == 2) ? 1 : 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ready must be low for exactly 17*CLK_DIV cycles after each accept, high otherwise.
  task automatic tick();
    @(negedge clk);
    #1;
    for (int b = 0; b < 3; b++)
      if (rdy[b] !== ((cyc >= ready_at[b]) ? 1'b1 : 1'b0)) rdy_bad[b]++;
  endtask

  task automatic clr(input int b);
    cnt[b] = 0; rises[b] = 0; viol[b] = 0; cs_rises[b] = 0;
  endtask

  task automatic put(input int b, input logic [8:0] item, output int acc);
    int n;
    n = 0;
    vld[b] = 1'b1;
    itm[b] = item;
    while (rdy[b] !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("put_wait", 32'(n < 300), 32'd1);
    acc = cyc + 1;
    ready_at[b] = acc + 17 * div_of(b);
    tick();
    vld[b] = 1'b0;
  endtask

  task automatic wait_idle(input int b, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((bsy[b] !== 1'b0 || csn[b] !== 1'b1) && n < 400);
    check(tag, 32'(n < 400), 32'd1);
    tick();
  endtask

  initial begin
    int a1, a2, a3, n, guard, exp_n;
    logic pend;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_cs_n",  32'(csn[0]),  32'd1);
    check("rst_sck",   32'(sck[0]),  32'd0);
    check("rst_mosi",  32'(mosi[0]), 32'd0);
    check("rst_dc",    32'(dcs[0]),  32'd0);
    check("rst_busy",  32'(bsy[0]),  32'd0);
    check("rst_ready", 32'(rdy[0]),  32'd1);
    $display("reset: cs_n=%b sck=%b mosi=%b dc=%b busy=%b ready=%b",
             csn[0], sck[0], mosi[0], dcs[0], bsy[0], rdy[0]);

    // Single command 0x2A
    clr(0);
    put(0, 9'h12A, a1);
    wait_idle(0, "t1_idle");
    check("t1_count",   32'(cnt[0]), 32'd1);
    check("t1_item",    32'(cap[0][0]), 32'h12A);
    check("t1_rises",   32'(rises[0]), 32'd8);
    check("t1_lastfall", 32'(last_fall[0] - a1), 32'd34);
    check("t1_cs_hold", 32'(cs_rises[0]), 32'd1);
    check("t1_viol",    32'(viol[0]), 32'd0);
    $display("single cmd: item=%h accept@%0d lastfall@%0d", cap[0][0], a1, last_fall[0]);

    // Burst: command 0x2C then data 0xF8, 0x1F with valid held
    clr(0);
    put(0, 9'h12C, a1);
    put(0, 9'h0F8, a2);
    put(0, 9'h01F, a3);
    wait_idle(0, "t2_idle");
    check("t2_gap12",  32'(a2 - a1), 32'd35);
    check("t2_gap23",  32'(a3 - a2), 32'd35);
    check("t2_count",  32'(cnt[0]), 32'd3);
    check("t2_item0",  32'(cap[0][0]), 32'h12C);
    check("t2_item1",  32'(cap[0][1]), 32'h0F8);
    check("t2_item2",  32'(cap[0][2]), 32'h01F);
    check("t2_cs_once", 32'(cs_rises[0]), 32'd1);
    check("t2_viol",   32'(viol[0]), 32'd0);
    $display("burst: %h %h %h cs_rises=%0d", cap[0][0], cap[0][1], cap[0][2], cs_rises[0]);

    // CS_HOLD=0: CS# deasserts between bytes
    clr(1);
    put(1, 9'h0AA, a1);
    put(1, 9'h055, a2);
    wait_idle(1, "t3_idle");
    check("t3_gap",    32'(a2 - a1), 32'd35);
    check("t3_count",  32'(cnt[1]), 32'd2);
    check("t3_item0",  32'(cap[1][0]), 32'h0AA);
    check("t3_item1",  32'(cap[1][1]), 32'h055);
    check("t3_cs_rises", 32'(cs_rises[1]), 32'd2);
    check("t3_viol",   32'(viol[1]), 32'd0);
    $display("cs_hold0: %h %h cs_rises=%0d", cap[1][0], cap[1][1], cs_rises[1]);

    // Random valid with CLK_DIV=1, 64 items
    clr(2);
    exp_n = 0;
    guard = 0;
    pend = 1'b0;
    itm[2] = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))};
    while (guard < 6000) begin
      tick();
      guard++;
      if (pend) begin
        expq[exp_n] = itm[2];
        exp_n++;
        itm[2] = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))};
      end
      if (exp_n == 64) break;
      vld[2] = 1'($urandom_range(0, 1));
      pend = vld[2] && rdy[2];
      if (pend) ready_at[2] = cyc + 18;
    end
    vld[2] = 1'b0;
    check("t4_accepts", 32'(exp_n), 32'd64);
    wait_idle(2, "t4_idle");
    check("t4_count", 32'(cnt[2]), 32'd64);
    for (int k = 0; k < 64; k++) begin
      check($sformatf("t4_item%0d", k), 32'(cap[2][k]), 32'(expq[k]));
      $display("rand[%0d]: sent=%h got=%h", k, expq[k], cap[2][k]);
    end
    check("t4_viol", 32'(viol[2]), 32'd0);

    // Reset in the middle of a byte
    clr(0);
    put(0, 9'h0C3, a1);
    n = 0;
    while (rises[0] < 3 && n < 200) begin
      tick();
      n++;
    end
    check("t5_wait", 32'(n < 200), 32'd1);
    rst_n = 1'b0;
    ready_at[0] = 0;
    #1;
    check("t5_cs_n",  32'(csn[0]),  32'd1);
    check("t5_sck",   32'(sck[0]),  32'd0);
    check("t5_mosi",  32'(mosi[0]), 32'd0);
    check("t5_dc",    32'(dcs[0]),  32'd0);
    check("t5_busy",  32'(bsy[0]),  32'd0);
    check("t5_ready", 32'(rdy[0]),  32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    clr(0);
    put(0, 9'h011, a1);
    wait_idle(0, "t5_idle");
    check("t5_count",    32'(cnt[0]), 32'd1);
    check("t5_item",     32'(cap[0][0]), 32'h011);
    check("t5_rises",    32'(rises[0]), 32'd8);
    check("t5_lastfall", 32'(last_fall[0] - a1), 32'd34);
    check("t5_viol",     32'(viol[0]), 32'd0);
    $display("reset mid-byte: next item=%h rises=%0d", cap[0][0], rises[0]);

    // Accept on the same edge the GAP hold expires
    clr(0);
    put(0, 9'h033, a1);
    n = 0;
    while (cyc < a1 + 37 && n < 100) begin
      tick();
      n++;
    end
    put(0, 9'h044, a2);
    wait_idle(0, "t6_idle");
    check("t6_accept_edge", 32'(a2 - a1), 32'd38);
    check("t6_count",  32'(cnt[0]), 32'd2);
    check("t6_item1",  32'(cap[0][1]), 32'h044);
    check("t6_cs_once", 32'(cs_rises[0]), 32'd1);
    check("t6_viol",   32'(viol[0]), 32'd0);
    $display("gap race: accept@+%0d cs_rises=%0d", a2 - a1, cs_rises[0]);

    for (int b = 0; b < 3; b++)
      check($sformatf("ready_decode%0d", b), 32'(rdy_bad[b]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
